// File: rtl/maze_player.sv
// Maze player: moves a cursor through a 15x10 wall maze from synchronized button presses.
// Optional MAZE_PLAYER_DEBOUNCE_EN adds a 16-bit stability debouncer per button.
module maze_player (
  input  logic         clk,
  input  logic         rst,
  input  logic         maze_valid,
  input  logic [159:0] h_walls,
  input  logic [164:0] v_walls,
  input  logic [3:0]   btn,
  output logic [3:0]   player_x,
  output logic [3:0]   player_y,
  output logic [9:0]   moves,
  output logic         won,
  output logic         bump
);

  localparam int unsigned X_MAX     = 14;
  localparam int unsigned Y_MAX     = 9;
  localparam int unsigned MOVES_MAX = 1023;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_WON  = 2'd2;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

  logic [3:0] sync1_q, sync2_q, prev_q, level;
  logic [3:0] press;

  logic [1:0] state_q, state_d;
  logic [3:0] x_q, x_d, y_q, y_d;
  logic [9:0] moves_q, moves_d;
  logic       won_q, won_d;
  logic       bump_q, bump_d;

  // Two-flop synchronizer plus rising-edge history of the (debounced) level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef MAZE_PLAYER_DEBOUNCE_EN
  logic [3:0]  deb_q;
  logic [15:0] cnt_q [4];

  // Level flips only after 65535 consecutive cycles disagreeing with it
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == 16'hFFFE) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign level = deb_q;
`else
  assign level = sync2_q;
`endif

  assign press = level & ~prev_q;

  logic [7:0] v_up_idx, v_dn_idx, h_l_idx, h_r_idx;
  logic       single, blocked;
  logic [3:0] nx, ny;

  assign v_up_idx = 8'(y_q) * 8'd15 + 8'(x_q);
  assign v_dn_idx = (8'(y_q) + 8'd1) * 8'd15 + 8'(x_q);
  assign h_l_idx  = {y_q, x_q};
  assign h_r_idx  = {y_q, x_q} + 8'd1;
  assign single   = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);

  // Target cell and wall/border check for a one-hot request
  always_comb begin
    nx      = x_q;
    ny      = y_q;
    blocked = 1'b1;
    if (press[BTN_UP]) begin
      ny      = y_q - 4'd1;
      blocked = (y_q == 4'd0) || v_walls[v_up_idx];
    end else if (press[BTN_DOWN]) begin
      ny      = y_q + 4'd1;
      blocked = (y_q == 4'(Y_MAX)) || v_walls[v_dn_idx];
    end else if (press[BTN_LEFT]) begin
      nx      = x_q - 4'd1;
      blocked = (x_q == 4'd0) || h_walls[h_l_idx];
    end else if (press[BTN_RIGHT]) begin
      nx      = x_q + 4'd1;
      blocked = (x_q == 4'(X_MAX)) || h_walls[h_r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      moves_q <= '0;
      won_q   <= 1'b0;
      bump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      moves_q <= moves_d;
      won_q   <= won_d;
      bump_q  <= bump_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    moves_d = moves_q;
    bump_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d     = '0;
        y_d     = '0;
        moves_d = '0;
        if (maze_valid) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (!maze_valid) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          moves_d = '0;
        end else if (single) begin
          if (blocked) begin
            bump_d = 1'b1;
          end else begin
            x_d = nx;
            y_d = ny;
            if (moves_q != 10'(MOVES_MAX)) moves_d = moves_q + 10'd1;
            if (nx == 4'(X_MAX) && ny == 4'(Y_MAX)) state_d = S_WON;
          end
        end
      end
      S_WON: begin
        if (!maze_valid) begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          moves_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    won_d = (state_d == S_WON);
  end

  assign player_x = x_q;
  assign player_y = y_q;
  assign moves    = moves_q;
  assign won      = won_q;
  assign bump     = bump_q;

endmodule
